writeback_store: RTL



---
 rtl/writeback_store.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/writeback_store.sv
// rtl/writeback_store.sv - writeback stage: register-file write port and two-beat bus store (optional WB_FORWARD_EN bypass outputs)
module writeback_store #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [BUS_DATA_WIDTH-1:0] inReadData,
    input  logic [BUS_DATA_WIDTH-1:0] inResult,
    input  logic [BUS_DATA_WIDTH-1:0] inDataReg2,
    input  logic [4:0]                inDestRegister,
    input  logic                      inMemOrReg,
    input  logic                      inRegWrite,
    input  logic                      inMemWrite,
    input  logic [1:0]                inStoreType,
    input  logic                      bus_reqack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      outRegWriteEn,
    output logic [4:0]                outWriteReg,
    output logic [BUS_DATA_WIDTH-1:0] outWriteData,
    output logic                      outStall,
`ifdef WB_FORWARD_EN
    output logic                      outFwdValid,
    output logic [4:0]                outFwdReg,
    output logic [BUS_DATA_WIDTH-1:0] outFwdData,
`endif
    output logic                      outStoreDone
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    // Write request to the memory target; the low two bits carry the store size.
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_BASE = BUS_TAG_WIDTH'(13'h0100);

    state_t                    state, state_next;
    logic [BUS_DATA_WIDTH-1:0] addr, addr_next;
    logic [BUS_DATA_WIDTH-1:0] data, data_next;
    logic [1:0]                stype, stype_next;

    logic                      reqcyc_next;
    logic [BUS_DATA_WIDTH-1:0] req_next;
    logic [BUS_TAG_WIDTH-1:0]  reqtag_next;
    logic                      wen_next;
    logic [4:0]                wreg_next;
    logic [BUS_DATA_WIDTH-1:0] wdata_next;
    logic                      done_next;
    logic                      reg_write_ok;
    logic [BUS_DATA_WIDTH-1:0] sel_data;

    assign reg_write_ok = inRegWrite & ~inMemWrite & (inDestRegister != 5'd0);
    assign sel_data     = inMemOrReg ? inReadData : inResult;

`ifdef WB_FORWARD_EN
    assign outFwdValid = (state == IDLE) & reg_write_ok;
    assign outFwdReg   = inDestRegister;
    assign outFwdData  = sel_data;
`endif

    always_comb begin
        state_next  = state;
        addr_next   = addr;
        data_next   = data;
        stype_next  = stype;
        reqcyc_next = bus_reqcyc;
        req_next    = bus_req;
        reqtag_next = bus_reqtag;
        wen_next    = 1'b0;
        wreg_next   = outWriteReg;
        wdata_next  = outWriteData;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                wen_next    = reg_write_ok;
                wreg_next   = inDestRegister;
                wdata_next  = sel_data;
                reqcyc_next = 1'b0;
                req_next    = '0;
                reqtag_next = '0;
                if (inMemWrite) begin
                    addr_next   = inResult;
                    data_next   = inDataReg2;
                    stype_next  = inStoreType;
                    state_next  = ADDR;
                    reqcyc_next = 1'b1;
                    req_next    = inResult;
                    reqtag_next = TAG_BASE | BUS_TAG_WIDTH'(inStoreType);
                end
            end
            ADDR: begin
                // Unacked beats repeat unchanged until the bus takes them.
                req_next = addr;
                if (bus_reqack) begin
                    state_next  = DATA;
                    req_next    = data;
                    reqtag_next = TAG_BASE | BUS_TAG_WIDTH'(stype);
                end
            end
            DATA: begin
                req_next = data;
                if (bus_reqack) begin
                    state_next  = IDLE;
                    done_next   = 1'b1;
                    reqcyc_next = 1'b0;
                    req_next    = '0;
                    reqtag_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr          <= '0;
            data          <= '0;
            stype         <= '0;
            bus_reqcyc    <= 1'b0;
            bus_req       <= '0;
            bus_reqtag    <= '0;
            outRegWriteEn <= 1'b0;
            outWriteReg   <= '0;
            outWriteData  <= '0;
            outStall      <= 1'b0;
            outStoreDone  <= 1'b0;
        end else begin
            state         <= state_next;
            addr          <= addr_next;
            data          <= data_next;
            stype         <= stype_next;
            bus_reqcyc    <= reqcyc_next;
            bus_req       <= req_next;
            bus_reqtag    <= reqtag_next;
            outRegWriteEn <= wen_next;
            outWriteReg   <= wreg_next;
            outWriteData  <= wdata_next;
            outStall      <= (state_next != IDLE);
            outStoreDone  <= done_next;
        end
    end

endmodule
